// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types, mode constants and Gray helper for the truth-table engine
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  // Callers truncate the result to their own row width.
  function automatic int bin2gray(input int b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/tt_row_seq.sv
// rtl/tt_row_seq.sv - sweep step counter with binary/Gray row mapping and last-row detect
module tt_row_seq
  import tt_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            mode_in,
  input  logic            adv,
  output logic [N_IN-1:0] row_x,
  output logic            last
);

  logic [N_IN-1:0] step_q, step_d;
  logic            mode_q, mode_d;

  always_comb begin
    step_d = step_q;
    mode_d = mode_q;
    if (load) begin
      step_d = '0;
      mode_d = mode_in;
    end else if (adv) begin
      // Wraps to zero only on the final beat, which also leaves RUN.
      step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      mode_q <= MODE_BIN;
    end else begin
      step_q <= step_d;
      mode_q <= mode_d;
    end
  end

  assign last  = &step_q;
  assign row_x = (mode_q == MODE_GRAY) ? N_IN'(bin2gray(int'(step_q))) : step_q;

endmodule

// File: rtl/truth_table_engine.sv
// rtl/truth_table_engine.sv - programmable LUT functions swept row by row over a valid/ready stream
module truth_table_engine
  import tt_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int N_FN = 5,
  localparam int R     = 1 << N_IN,
  localparam int IDX_W = (N_FN > 1) ? $clog2(N_FN) : 1,
  localparam int CNT_W = N_IN + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [R-1:0]          cfg_tt,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [N_IN-1:0]       row_x,
  output logic [N_FN-1:0]       row_f,
  output logic                  done,
  output logic [N_FN*CNT_W-1:0] ones_cnt,
  output logic [N_FN-1:0]       taut,
  output logic [N_FN-1:0]       contra
);

  state_e               state_q, state_d;
  logic [R-1:0]         lut_q [N_FN];
  logic [R-1:0]         lut_d [N_FN];
  logic [N_FN*CNT_W-1:0] ones_q, ones_d;
  logic [N_FN-1:0]      taut_q, taut_d;
  logic [N_FN-1:0]      contra_q, contra_d;
  logic                 sweep_load;
  logic                 beat;
  logic                 last;

  tt_row_seq #(.N_IN(N_IN)) u_row_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (sweep_load),
    .mode_in(mode),
    .adv    (beat),
    .row_x  (row_x),
    .last   (last)
  );

  always_comb begin
    for (int k = 0; k < N_FN; k++) begin
      row_f[k] = lut_q[k][row_x];
    end
  end

  always_comb begin
    state_d    = state_q;
    lut_d      = lut_q;
    ones_d     = ones_q;
    taut_d     = taut_q;
    contra_d   = contra_q;
    sweep_load = 1'b0;
    beat       = 1'b0;
    case (state_q)
      IDLE: begin
        // An out-of-range index matches no slot, so the write is dropped.
        for (int k = 0; k < N_FN; k++) begin
          if (cfg_we && (cfg_idx == IDX_W'(k))) begin
            lut_d[k] = cfg_tt;
          end
        end
        if (start) begin
          sweep_load = 1'b1;
          ones_d     = '0;
          taut_d     = '0;
          contra_d   = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (row_ready) begin
          beat = 1'b1;
          for (int k = 0; k < N_FN; k++) begin
            ones_d[k*CNT_W +: CNT_W] = ones_q[k*CNT_W +: CNT_W] + CNT_W'(row_f[k]);
          end
          if (last) begin
            // Flags come from the final totals so they are valid alongside done.
            for (int k = 0; k < N_FN; k++) begin
              taut_d[k]   = (ones_d[k*CNT_W +: CNT_W] == CNT_W'(R));
              contra_d[k] = (ones_d[k*CNT_W +: CNT_W] == '0);
            end
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lut_q    <= '{default: '0};
      ones_q   <= '0;
      taut_q   <= '0;
      contra_q <= '0;
    end else begin
      state_q  <= state_d;
      lut_q    <= lut_d;
      ones_q   <= ones_d;
      taut_q   <= taut_d;
      contra_q <= contra_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign row_valid = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign ones_cnt  = ones_q;
  assign taut      = taut_q;
  assign contra    = contra_q;

endmodule

// File: tb/tb_truth_table_engine.sv
// tb/tb_truth_table_engine.sv - randomized self-checking bench against a row-sweep reference model
module tb_truth_table_engine;

  localparam int N_IN  = 2;
  localparam int N_FN  = 5;
  localparam int R     = 1 << N_IN;
  localparam int IDX_W = $clog2(N_FN);
  localparam int CNT_W = N_IN + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cfg_we = 1'b0;
  logic [IDX_W-1:0]       cfg_idx = '0;
  logic [R-1:0]           cfg_tt = '0;
  logic                   start = 1'b0;
  logic                   mode = 1'b0;
  logic                   row_ready = 1'b0;
  logic                   busy, row_valid, done;
  logic [N_IN-1:0]        row_x;
  logic [N_FN-1:0]        row_f, taut, contra;
  logic [N_FN*CNT_W-1:0]  ones_cnt;

  int checks = 0;
  int failures = 0;
  logic [R-1:0] lut_m [N_FN];

  truth_table_engine #(.N_IN(N_IN), .N_FN(N_FN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_tt   (cfg_tt),
    .start    (start),
    .mode     (mode),
    .busy     (busy),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_x    (row_x),
    .row_f    (row_f),
    .done     (done),
    .ones_cnt (ones_cnt),
    .taut     (taut),
    .contra   (contra)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_row_valid"}, 64'(row_valid), 64'(0));
    chk({tag, "_done"},      64'(done),      64'(0));
    chk({tag, "_row_x"},     64'(row_x),     64'(0));
    chk({tag, "_row_f"},     64'(row_f),     64'(0));
    chk({tag, "_ones_cnt"},  64'(ones_cnt),  64'(0));
    chk({tag, "_taut"},      64'(taut),      64'(0));
    chk({tag, "_contra"},    64'(contra),    64'(0));
  endtask

  task automatic check_results(input string tag);
    logic [N_FN*CNT_W-1:0] e_cnt;
    logic [N_FN-1:0]       e_taut, e_contra;
    for (int k = 0; k < N_FN; k++) begin
      int ones;
      ones = $countones(lut_m[k]);
      e_cnt[k*CNT_W +: CNT_W] = CNT_W'(ones);
      e_taut[k]   = (ones == R);
      e_contra[k] = (ones == 0);
    end
    chk({tag, "_ones_cnt"}, 64'(ones_cnt), 64'(e_cnt));
    chk({tag, "_taut"},     64'(taut),     64'(e_taut));
    chk({tag, "_contra"},   64'(contra),   64'(e_contra));
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1.
  task automatic cfg_write(input int idx, input logic [R-1:0] tt);
    cfg_we  = 1'b1;
    cfg_idx = IDX_W'(idx);
    cfg_tt  = tt;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (idx < N_FN) lut_m[idx] = tt;
  endtask

  // stall: 0 = always ready, 1 = 1,0,0 pattern, 2 = random. abort_at < 0 disables the reset abort.
  task automatic run_sweep(input logic m, input int stall, input bit inject, input int abort_at,
                           input bit done_poke, input bit wr_at_start, input int wr_idx,
                           input logic [R-1:0] wr_tt);
    int  beat = 0;
    int  cyc = 0;
    bit  seen_done = 0;
    bit  prev_last = 0;
    logic [N_IN-1:0] exp_x;
    logic [N_FN-1:0] exp_f;
    start = 1'b1;
    mode  = m;
    if (wr_at_start) begin
      cfg_we  = 1'b1;
      cfg_idx = IDX_W'(wr_idx);
      cfg_tt  = wr_tt;
      if (wr_idx < N_FN) lut_m[wr_idx] = wr_tt;
    end
    @(posedge clk); #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    mode   = 1'($urandom_range(1, 0));
    chk("busy_after_start", 64'(busy), 64'(1));
    while (!seen_done && cyc < 200) begin
      case (stall)
        0:       row_ready = 1'b1;
        1:       row_ready = (cyc % 3 == 0);
        default: row_ready = 1'($urandom_range(1, 0));
      endcase
      if (done) begin
        seen_done = 1;
        chk("done_after_final_beat", 64'(prev_last), 64'(1));
        chk("beat_count", 64'(beat), 64'(R));
        chk("done_row_valid", 64'(row_valid), 64'(0));
        chk("done_busy", 64'(busy), 64'(0));
        check_results("done");
        if (done_poke) begin
          cfg_we  = 1'b1;
          cfg_idx = IDX_W'($urandom_range(N_FN - 1, 0));
          cfg_tt  = R'($urandom);
          start   = 1'b1;
          mode    = ~m;
        end
      end else begin
        int xi;
        xi    = m ? (beat ^ (beat >> 1)) : beat;
        exp_x = xi[N_IN-1:0];
        for (int k = 0; k < N_FN; k++) exp_f[k] = lut_m[k][exp_x];
        chk("row_valid", 64'(row_valid), 64'(1));
        chk("row_x", 64'(row_x), 64'(exp_x));
        chk("row_f", 64'(row_f), 64'(exp_f));
        if (beat == abort_at) begin
          rst_n = 1'b0;
          #1;
          for (int k = 0; k < N_FN; k++) lut_m[k] = '0;
          check_all_zero("abort");
          @(posedge clk); #1;
          rst_n = 1'b1;
          row_ready = 1'b0;
          for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 64'(done), 64'(0));
            chk("abort_idle", 64'(busy), 64'(0));
            @(posedge clk); #1;
          end
          return;
        end
        if (inject && beat == 1) begin
          cfg_we  = 1'b1;
          cfg_idx = IDX_W'(1);
          cfg_tt  = '0;
          start   = 1'b1;
          mode    = ~m;
        end
        prev_last = row_ready && (beat == R - 1);
        if (row_ready) beat++;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      start  = 1'b0;
      cyc++;
    end
    row_ready = 1'b0;
    if (!seen_done) begin
      chk("done_timeout", 64'(0), 64'(1));
    end else begin
      chk("done_pulse_width", 64'(done), 64'(0));
      chk("idle_after_done", 64'(busy), 64'(0));
      check_results("hold");
    end
  endtask

  initial begin
    for (int k = 0; k < N_FN; k++) lut_m[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    cfg_write(0, 4'b0001);
    cfg_write(1, 4'b1111);
    cfg_write(2, 4'b1010);
    cfg_write(3, 4'b0111);
    cfg_write(4, 4'b1001);

    run_sweep(1'b0, 0, 0, -1, 0, 0, 0, '0);
    chk("s1_ones_cnt_const", 64'(ones_cnt), 64'(15'b010_011_010_100_001));
    chk("s1_taut_const", 64'(taut), 64'(5'b00010));
    run_sweep(1'b1, 0, 0, -1, 0, 0, 0, '0);
    run_sweep(1'b0, 1, 0, -1, 0, 0, 0, '0);
    run_sweep(1'b1, 1, 1, -1, 0, 0, 0, '0);
    chk("s4_taut1", 64'(taut[1]), 64'(1));
    cfg_write(1, 4'b0000);
    run_sweep(1'b0, 0, 0, -1, 1, 0, 0, '0);
    chk("s4_contra1", 64'(contra[1]), 64'(1));
    run_sweep(1'b0, 0, 0, 2, 0, 0, 0, '0);
    run_sweep(1'b1, 2, 0, -1, 0, 0, 0, '0);
    chk("s5_contra_all", 64'(contra), 64'(5'b11111));
    run_sweep(1'b0, 0, 0, -1, 0, 1, 0, 4'b1111);
    chk("s6_taut0", 64'(taut[0]), 64'(1));

    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = $urandom_range(3, 0);
      for (int w = 0; w < nw; w++) begin
        cfg_write($urandom_range(7, 0), R'($urandom));
      end
      run_sweep(1'($urandom_range(1, 0)), 2, 1'($urandom_range(1, 0)), -1,
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                $urandom_range(7, 0), R'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
